usb_fifo_loopback: RTL and testbench
====================================

Name: usb_fifo_loopback

Overview:
- Master-side controller for a Cypress FX2-style slave-FIFO interface: drains 16-bit words from the host OUT endpoint (EP2, FIFOADR=00) into an internal buffer, then writes them back unchanged to the IN endpoint (EP6, FIFOADR=10).
- Half-duplex loopback: never reads and writes in the same cycle.
- Sits between the FX2 pins and the board; exports state and word counters for debug.

Parameters:
- DEPTH, 16, internal buffer depth in words (power of two, ≥2).
- AW, 4, buffer address width = log2(DEPTH).

Ports:
- CLKOUT  in  1  system/interface clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (the name is kept from the codebase; 1 = reset).
- FLAGD  in  1  EP6 full flag, active low: 1 = room available, 0 = full.
- FLAGA  in  1  EP2 empty flag, active low: 1 = data available, 0 = empty.
- SLWR  out  1  slave write strobe, active low.
- SLRD  out  1  slave read strobe, active low.
- SLOE  out  1  slave output enable, active low.
- IFCLK  out  1  FX2 interface clock, ~CLKOUT (combinational).
- FIFOADR  out  2  endpoint select: 00 = EP2, 10 = EP6.
- FDATA  inout  16  data bus; driven only in WR_SETUP/WRITE, else 16'hzzzz.
- cState  out  3  current state encoding.
- WCount  out  16  total words written to EP6.
- RCount  out  16  total words read from EP2.

Behaviour:
- States: IDLE=0, RD_SETUP=1, READ=2, WR_SETUP=3, WRITE=4. Codes 5–7 go to IDLE.
- Reset (rst_n=1 at clock edge):
  - state=IDLE; buffer pointers/count=0; WCount=RCount=0.
  - SLWR=SLRD=SLOE=1, FIFOADR=00, FDATA released.
  - Reset mid-operation aborts immediately; buffered data is discarded.
- IDLE:
  - FLAGA=1 -> RD_SETUP.
  - Else if buffer non-empty -> WR_SETUP.
  - Else stay.
- RD_SETUP: FIFOADR=00, SLOE=0, SLRD=1. One cycle address/OE setup, then -> READ.
- READ: FIFOADR=00, SLOE=0.
  - SLRD = 0 combinationally while FLAGA=1 and buffer not full.
  - On each such edge: FDATA is pushed to the buffer and RCount increments (wraps at 16 bits).
  - Exit when FLAGA=0 or the buffer is full (evaluated after the push):
    - to WR_SETUP if the buffer is non-empty;
    - to IDLE if the buffer is empty.
- WR_SETUP: FIFOADR=10, SLOE=1, FDATA drives the buffer head. One cycle, then -> WRITE.
- WRITE: FIFOADR=10, FDATA = buffer head.
  - SLWR = 0 combinationally while FLAGD=1 and buffer non-empty.
  - On each such edge: the head is popped and WCount increments (wraps).
  - FLAGD=0: hold, SLWR=1, data held.
  - Buffer becomes empty -> IDLE.
- Latency:
  - First SLRD low: 2 cycles after FLAGA rises in IDLE.
  - First SLWR low: 2 cycles after leaving READ.
- Flags are sampled raw; no synchronizer, since the FX2 is clocked by IFCLK.
- Word order is preserved (FIFO); data is unmodified.
- Counters and buffer count are modulo 2^width; there is no overflow flag.

Decomposition:
- Package usb_fifo_pkg:
  - state enum constants (IDLE..WRITE, 3 bits);
  - ADDR_EP2=2'b00, ADDR_EP6=2'b10.
- Sub-module usb_word_fifo: synchronous DEPTH×16 FIFO with push, pop, dout=head, full, empty, sync reset.
- The top level holds the FSM, strobes, tristate and counters.

Test Plan:
- Reset: rst_n=1 for 3 cycles -> cState=0, SLWR=SLRD=SLOE=1, FIFOADR=00, WCount=RCount=0, FDATA high-Z.
- Basic loopback: FLAGA=1 for 5 read strobes with a source incrementing 1..5, then FLAGA=0, FLAGD=1 -> RCount=5, then EP6 receives 1,2,3,4,5 on SLWR-low edges, WCount=5, return to IDLE.
- Full stall: FLAGA=1 with a continuous source, FLAGD=0 -> READ stops after DEPTH=16 words (RCount=16). Then WRITE holds with SLWR=1. Release FLAGD=1 -> 16 writes, WCount=16.
- Empty-flag gap: FLAGA drops after 3 words, rises 2 cycles later while writing -> 3 words written first, then a new read burst starts via IDLE->RD_SETUP.
- Bus discipline: in every cycle FIFOADR=00 ⇒ FDATA undriven by the DUT; SLRD and SLWR are never both 0; SLOE=0 only with FIFOADR=00.
- Mid-operation reset: assert rst_n during WRITE with 4 words buffered -> next cycle IDLE, counters 0, buffer empty, no further SLWR pulses.

Source files
------------

// File: rtl/usb_fifo_pkg.sv
// Shared state encoding and FX2 endpoint addresses for the slave-FIFO loopback.
package usb_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_SETUP = 3'd1,
    READ     = 3'd2,
    WR_SETUP = 3'd3,
    WRITE    = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_EP2 = 2'b00;
  localparam logic [1:0] ADDR_EP6 = 2'b10;

endpackage

// File: rtl/usb_word_fifo.sv
// DEPTHx16 synchronous FIFO, head visible combinationally on o_dout.
// Push when full and pop when empty are ignored.
module usb_word_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [15:0]   i_din,
  input  logic          i_pop,
  output logic [15:0]   o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/usb_fifo_loopback.sv
// FX2 slave-FIFO master: drains EP2 into a local buffer, then writes it back to EP6.
// First SLRD low 2 cycles after FLAGA rises; first SLWR low 2 cycles after READ exits; FLAGD=0 stalls writes.
module usb_fifo_loopback
  import usb_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        CLKOUT,
  input  logic        rst_n,
  input  logic        FLAGD,
  input  logic        FLAGA,
  output logic        SLWR,
  output logic        SLRD,
  output logic        SLOE,
  output logic        IFCLK,
  output logic [1:0]  FIFOADR,
  inout  wire  [15:0] FDATA,
  output logic [2:0]  cState,
  output logic [15:0] WCount,
  output logic [15:0] RCount
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_wcount;
  logic [15:0] r_rcount;
  logic        w_rd;
  logic        w_wr;
  logic        w_drive;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  logic [AW:0] w_cnt_after;
  logic [15:0] w_head;

  usb_word_fifo #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .i_clk   (CLKOUT),
    .i_rst   (rst_n),
    .i_push  (w_rd),
    .i_din   (FDATA),
    .i_pop   (w_wr),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_rd        = (r_state == READ)  && FLAGA && !w_full;
  assign w_wr        = (r_state == WRITE) && FLAGD && !w_empty;
  assign w_drive     = (r_state == WR_SETUP) || (r_state == WRITE);
  // READ exit is judged on the occupancy after this cycle's push lands.
  assign w_cnt_after = w_count + (AW+1)'(w_rd);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (FLAGA)         w_next = RD_SETUP;
        else if (!w_empty) w_next = WR_SETUP;
      end
      RD_SETUP: w_next = READ;
      READ: begin
        if (!FLAGA || (w_cnt_after == (AW+1)'(DEPTH)))
          w_next = (w_cnt_after != '0) ? WR_SETUP : IDLE;
      end
      WR_SETUP: w_next = WRITE;
      WRITE: begin
        if (w_empty || (w_wr && (w_count == (AW+1)'(1)))) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLKOUT) begin
    if (rst_n) begin
      r_state  <= IDLE;
      r_wcount <= '0;
      r_rcount <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd) r_rcount <= r_rcount + 16'd1;
      if (w_wr) r_wcount <= r_wcount + 16'd1;
    end
  end

  assign SLRD    = ~w_rd;
  assign SLWR    = ~w_wr;
  assign SLOE    = ~((r_state == RD_SETUP) || (r_state == READ));
  assign FIFOADR = w_drive ? ADDR_EP6 : ADDR_EP2;
  assign FDATA   = w_drive ? w_head : 16'hzzzz;
  assign IFCLK   = ~CLKOUT;
  assign cState  = r_state;
  assign WCount  = r_wcount;
  assign RCount  = r_rcount;

endmodule

// File: tb/tb_usb_fifo_loopback.sv
// Directed bench for usb_fifo_loopback with a behavioural FX2 endpoint pair.
module tb_usb_fifo_loopback;

  logic        CLKOUT;
  logic        rst_n;
  logic        FLAGD;
  logic        FLAGA;
  logic        SLWR;
  logic        SLRD;
  logic        SLOE;
  logic        IFCLK;
  logic [1:0]  FIFOADR;
  wire  [15:0] FDATA;
  logic [2:0]  cState;
  logic [15:0] WCount;
  logic [15:0] RCount;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_rd    = 0;
  int          n_wr    = 0;
  int          bus_err = 0;
  logic [15:0] src_base = 16'd1;
  logic [15:0] got_mem [256];
  logic [15:0] tb_src;
  logic [15:0] tb_val;
  logic        tb_en;

  usb_fifo_loopback dut (
    .CLKOUT  (CLKOUT),
    .rst_n   (rst_n),
    .FLAGD   (FLAGD),
    .FLAGA   (FLAGA),
    .SLWR    (SLWR),
    .SLRD    (SLRD),
    .SLOE    (SLOE),
    .IFCLK   (IFCLK),
    .FIFOADR (FIFOADR),
    .FDATA   (FDATA),
    .cState  (cState),
    .WCount  (WCount),
    .RCount  (RCount)
  );

  initial CLKOUT = 1'b0;
  always #5 CLKOUT = ~CLKOUT;

  // EP2 side: the host FIFO drives the bus whenever EP2 is addressed; data only under SLOE.
  assign tb_src = src_base + n_rd[15:0];
  assign tb_en  = (FIFOADR == 2'b00);
  assign tb_val = (SLOE == 1'b0) ? tb_src : 16'h0000;
  assign FDATA  = tb_en ? tb_val : 16'hzzzz;

  // Pre-edge sampling of strobes and bus rules, committed just after the edge.
  always begin : monitor
    logic        rd_now;
    logic        wr_now;
    logic [15:0] wdat;
    @(negedge CLKOUT);
    #4;
    if (!SLRD && !SLWR) bus_err++;
    if (!SLOE && FIFOADR != 2'b00) bus_err++;
    if (FIFOADR == 2'b00 && FDATA !== tb_val) bus_err++;
    if (IFCLK !== 1'b1) bus_err++;
    rd_now = !SLRD;
    wr_now = !SLWR;
    wdat   = FDATA;
    @(posedge CLKOUT);
    #1;
    if (rd_now) n_rd++;
    if (wr_now && n_wr < 256) begin
      got_mem[n_wr] = wdat;
      n_wr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLKOUT);
    #1;
  endtask

  task automatic wait_rd(input int target, input string tag);
    int n = 0;
    while (n_rd < target && n < 300) begin
      step();
      n++;
    end
    if (n_rd < target) check(tag, n_rd, target);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (cState !== s && n < 300) begin
      step();
      n++;
    end
    if (cState !== s) check(tag, cState, s);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
  endtask

  initial begin : stim
    int rd0;
    int wr0;
    rst_n = 1'b1;
    FLAGA = 1'b0;
    FLAGD = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_state", cState, 0);
    check("rst_slwr", SLWR, 1);
    check("rst_slrd", SLRD, 1);
    check("rst_sloe", SLOE, 1);
    check("rst_addr", FIFOADR, 2'b00);
    check("rst_wcnt", WCount, 0);
    check("rst_rcnt", RCount, 0);
    check("rst_ifclk", IFCLK, 1);
    rst_n = 1'b0;
    step();
    check("idle_hold", cState, 0);

    // Basic loopback of 1..5
    rd0 = n_rd; wr0 = n_wr;
    src_base = 16'd1 - rd0[15:0];
    FLAGA = 1'b1;
    step();
    check("lat_rdsetup", cState, 1);
    check("lat_slrd_hi", SLRD, 1);
    check("lat_sloe", SLOE, 0);
    step();
    check("lat_read", cState, 2);
    check("lat_slrd_lo", SLRD, 0);
    wait_rd(rd0 + 5, "basic_rd_timeout");
    FLAGA = 1'b0;
    step();
    check("basic_wrsetup", cState, 3);
    check("basic_rcnt", RCount, 5);
    check("basic_addr6", FIFOADR, 2'b10);
    check("basic_head", FDATA, 16'd1);
    step();
    check("basic_write", cState, 4);
    check("basic_slwr_lo", SLWR, 0);
    wait_state(3'd0, "basic_idle_timeout");
    check("basic_wcnt", WCount, 5);
    check("basic_nwr", n_wr - wr0, 5);
    for (int i = 0; i < 5; i++) check("basic_data", got_mem[wr0 + i], 16'(i + 1));

    // Full stall: 16 words buffered while EP6 is full
    do_reset();
    rd0 = n_rd; wr0 = n_wr;
    src_base = 16'h0100 - rd0[15:0];
    FLAGD = 1'b0;
    FLAGA = 1'b1;
    wait_rd(rd0 + 16, "stall_rd_timeout");
    FLAGA = 1'b0;
    check("stall_rcnt", RCount, 16);
    check("stall_state", cState, 3);
    check("stall_slrd", SLRD, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_slwr_hold", SLWR, 1);
      check("stall_data_hold", FDATA, 16'h0100);
    end
    check("stall_in_write", cState, 4);
    check("stall_wcnt0", WCount, 0);
    FLAGD = 1'b1;
    wait_state(3'd0, "stall_idle_timeout");
    check("stall_wcnt", WCount, 16);
    check("stall_rcnt_end", n_rd - rd0, 16);
    for (int i = 0; i < 16; i++) check("stall_data", got_mem[wr0 + i], 16'h0100 + 16'(i));

    // Empty-flag gap: 3 words, FLAGA returns while writing
    do_reset();
    rd0 = n_rd; wr0 = n_wr;
    src_base = 16'h0200 - rd0[15:0];
    FLAGA = 1'b1;
    wait_rd(rd0 + 3, "gap_rd_timeout");
    FLAGA = 1'b0;
    repeat (2) step();
    FLAGA = 1'b1;
    wait_state(3'd1, "gap_rdsetup_timeout");
    check("gap_wr_first", n_wr - wr0, 3);
    check("gap_rd_first", n_rd - rd0, 3);
    check("gap_wcnt", WCount, 3);
    wait_rd(rd0 + 5, "gap_rd2_timeout");
    FLAGA = 1'b0;
    wait_state(3'd0, "gap_idle_timeout");
    check("gap_wcnt_end", WCount, 5);
    check("gap_rcnt_end", RCount, 5);
    for (int i = 0; i < 5; i++) check("gap_data", got_mem[wr0 + i], 16'h0200 + 16'(i));

    // Reset during WRITE with 4 words buffered
    do_reset();
    rd0 = n_rd;
    src_base = 16'h0300 - rd0[15:0];
    FLAGD = 1'b0;
    FLAGA = 1'b1;
    wait_rd(rd0 + 4, "mid_rd_timeout");
    FLAGA = 1'b0;
    wait_state(3'd4, "mid_write_timeout");
    check("mid_rcnt", RCount, 4);
    rst_n = 1'b1;
    step();
    check("mid_state", cState, 0);
    check("mid_wcnt", WCount, 0);
    check("mid_rcnt0", RCount, 0);
    check("mid_slwr", SLWR, 1);
    rst_n = 1'b0;
    FLAGD = 1'b1;
    wr0 = n_wr;
    repeat (6) step();
    check("mid_no_writes", n_wr - wr0, 0);
    check("mid_stay_idle", cState, 0);
    check("mid_wcnt_end", WCount, 0);

    check("bus_discipline", bus_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
